// File: rtl/uart_tx_encoder.sv
// Response framer: header, payload bytes MSB first, then an XOR checksum, one byte per UART TX handshake.
// The first uart_wvld comes two cycles after accept; each later byte waits for uart_busy to rise and fall.
module uart_tx_encoder #(
    parameter int UART_NUM_DATA = 8,
    parameter int CMDLENGTH     = 4,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     sys_locked,
    input  logic                     send_req,
    input  logic [CMDLENGTH-1:0]     cmd_in,
    input  logic [DATA_WIDTH-1:0]    send_data,
    output logic                     send_ready,
    input  logic                     uart_busy,
    output logic [UART_NUM_DATA-1:0] uart_wdata,
    output logic                     uart_wvld,
    output logic                     frame_done
);

    localparam int NBYTES  = DATA_WIDTH / 8;
    localparam int CNT_W   = $clog2(NBYTES + 2);
    localparam int SHIFT_W = DATA_WIDTH + UART_NUM_DATA;

    localparam logic [CNT_W-1:0]         CNT_CSUM = CNT_W'(NBYTES + 1);
    localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
    localparam logic [CMDLENGTH-1:0]     CMD_CB   = CMDLENGTH'(1);
    localparam logic [CMDLENGTH-1:0]     CMD_AD   = CMDLENGTH'(2);
    localparam logic [UART_NUM_DATA-1:0] HDR_CB   = UART_NUM_DATA'(8'hCB);
    localparam logic [UART_NUM_DATA-1:0] HDR_AD   = UART_NUM_DATA'(8'hAD);
    localparam logic [UART_NUM_DATA-1:0] HDR_ERR  = UART_NUM_DATA'(8'hEE);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                   r_state;
    logic [SHIFT_W-1:0]       r_shift;
    logic [CNT_W-1:0]         r_cnt;
    logic [UART_NUM_DATA-1:0] r_csum;
    logic                     r_has_payload;
    logic                     r_send_ready;
    logic                     r_wvld;
    logic [UART_NUM_DATA-1:0] r_wdata;
    logic                     r_frame_done;

    logic [UART_NUM_DATA-1:0] w_hdr;
    logic                     w_hdr_payload;
    logic                     w_accept;
    logic                     w_last;
    logic [UART_NUM_DATA-1:0] w_cur_byte;
    logic [CNT_W-1:0]         w_cnt_next;

    always_comb begin
        w_hdr         = HDR_ERR;
        w_hdr_payload = 1'b0;
        if (cmd_in == CMD_CB) begin
            w_hdr         = HDR_CB;
            w_hdr_payload = 1'b1;
        end else if (cmd_in == CMD_AD) begin
            w_hdr         = HDR_AD;
            w_hdr_payload = 1'b1;
        end
    end

    // Code 0 is a no-op request: it is never accepted, so send_ready stays high.
    assign w_accept   = r_send_ready & sys_locked & send_req & (cmd_in != '0);
    assign w_last     = (r_cnt == CNT_CSUM);
    assign w_cur_byte = w_last ? r_csum : r_shift[SHIFT_W-1 -: UART_NUM_DATA];

    // Error frames skip straight from the header to the checksum; the counter saturates.
    always_comb begin
        w_cnt_next = r_cnt;
        if (!r_has_payload) begin
            w_cnt_next = CNT_CSUM;
        end else if (r_cnt != CNT_CSUM) begin
            w_cnt_next = r_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_csum        <= '0;
            r_has_payload <= 1'b0;
            r_send_ready  <= 1'b0;
            r_wvld        <= 1'b0;
            r_wdata       <= '0;
            r_frame_done  <= 1'b0;
        end else if (!sys_locked) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_csum       <= '0;
            r_send_ready <= 1'b0;
            r_wvld       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_wvld       <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_send_ready <= 1'b1;
                    if (w_accept) begin
                        r_shift       <= {w_hdr, send_data};
                        r_has_payload <= w_hdr_payload;
                        r_cnt         <= '0;
                        r_csum        <= '0;
                        r_send_ready  <= 1'b0;
                        r_state       <= SEND;
                    end
                end
                SEND: begin
                    r_send_ready <= 1'b0;
                    if (!uart_busy) begin
                        r_wvld  <= 1'b1;
                        r_wdata <= w_cur_byte;
                        if (!w_last) begin
                            r_csum <= r_csum ^ w_cur_byte;
                        end
                        r_state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    r_send_ready <= 1'b0;
                    if (uart_busy) begin
                        r_state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    r_send_ready <= 1'b0;
                    if (!uart_busy) begin
                        if (w_last) begin
                            r_frame_done <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_shift <= {r_shift[SHIFT_W-UART_NUM_DATA-1:0], {UART_NUM_DATA{1'b0}}};
                            r_cnt   <= w_cnt_next;
                            r_state <= SEND;
                        end
                    end
                end
                DONE: begin
                    r_send_ready <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_send_ready <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign send_ready = r_send_ready;
    assign uart_wvld  = r_wvld;
    assign uart_wdata = r_wdata;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_encoder.sv
// Directed bench for uart_tx_encoder with a UART TX model that holds busy for a fixed number of cycles.
module tb_uart_tx_encoder;

    localparam int BUSY_LEN = 10;

    logic        clk = 1'b0;
    logic        nrst;
    logic        sys_locked;
    logic        send_req;
    logic [3:0]  cmd_in;
    logic [15:0] send_data;
    logic        send_ready;
    logic        uart_busy;
    logic [7:0]  uart_wdata;
    logic        uart_wvld;
    logic        frame_done;

    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    assign uart_busy = model_busy | force_busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] got[$];
    int done_cnt = 0;
    int viol_cnt = 0;
    int busy_cnt = 0;
    logic prev_wvld = 1'b0;

    always #5 clk = ~clk;

    uart_tx_encoder #(.UART_NUM_DATA(8), .CMDLENGTH(4), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .sys_locked (sys_locked),
        .send_req   (send_req),
        .cmd_in     (cmd_in),
        .send_data  (send_data),
        .send_ready (send_ready),
        .uart_busy  (uart_busy),
        .uart_wdata (uart_wdata),
        .uart_wvld  (uart_wvld),
        .frame_done (frame_done)
    );

    // TX core model: captures each launched byte and raises busy for BUSY_LEN cycles.
    always @(negedge clk) begin
        if (uart_wvld) begin
            got.push_back(uart_wdata);
            if (uart_busy) viol_cnt = viol_cnt + 1;
            if (prev_wvld) viol_cnt = viol_cnt + 1;
            busy_cnt = BUSY_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        model_busy = (busy_cnt > 0);
        if (frame_done) done_cnt = done_cnt + 1;
        prev_wvld = uart_wvld;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic request(input logic [3:0] c, input logic [15:0] d);
        @(negedge clk);
        send_req  = 1'b1;
        cmd_in    = c;
        send_data = d;
        @(negedge clk);
        send_req  = 1'b0;
        cmd_in    = 4'hF;
        send_data = 16'hFFFF;
    endtask

    task automatic wait_done(input int start, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (done_cnt > start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (got.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; sys_locked = 1'b1; send_req = 1'b0; cmd_in = 4'h0; send_data = 16'h0;
        repeat (3) @(negedge clk);
        n_cmp++; if (send_ready !== 1'b0) begin n_bad++; $display("FAIL reset_send_ready got=%b want=0", send_ready); end
        n_cmp++; if (uart_wvld !== 1'b0) begin n_bad++; $display("FAIL reset_wvld got=%b want=0", uart_wvld); end
        n_cmp++; if (uart_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_wdata got=%h want=00", uart_wdata); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        nrst = 1'b1;
        @(negedge clk);
        n_cmp++; if (send_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_rise got=%b want=1", send_ready); end
    endtask

    task automatic test_frame(input string name, input logic [3:0] c, input logic [15:0] d,
                              input int nexp, input logic [31:0] exp_bytes);
        bit ok;
        int d0;
        logic [7:0] e;
        got.delete();
        d0 = done_cnt;
        viol_cnt = 0;
        request(c, d);
        n_cmp++; if (send_ready !== 1'b0) begin n_bad++; $display("FAIL %s_busy_ready got=%b want=0", name, send_ready); end
        wait_done(d0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_timeout got=no frame_done want=frame_done", name); end
        n_cmp++; if (got.size() != nexp) begin n_bad++; $display("FAIL %s_len got=%0d want=%0d", name, got.size(), nexp); end
        else begin
            for (int i = 0; i < nexp; i++) begin
                e = exp_bytes[31 - 8*i -: 8];
                n_cmp++; if (got[i] !== e) begin n_bad++; $display("FAIL %s_byte%0d got=%h want=%h", name, i, got[i], e); end
            end
        end
        @(negedge clk);
        n_cmp++; if (send_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready_after got=%b want=1", name, send_ready); end
        n_cmp++; if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL %s_done_pulses got=%0d want=1", name, done_cnt - d0); end
        n_cmp++; if (viol_cnt != 0) begin n_bad++; $display("FAIL %s_handshake got=%0d violations want=0", name, viol_cnt); end
    endtask

    task automatic test_cmd_zero();
        int d0;
        got.delete();
        d0 = done_cnt;
        request(4'h0, 16'h5555);
        n_cmp++; if (send_ready !== 1'b1) begin n_bad++; $display("FAIL cmd0_ready got=%b want=1", send_ready); end
        repeat (20) @(negedge clk);
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL cmd0_bytes got=%0d want=0", got.size()); end
        n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL cmd0_done got=%0d want=0", done_cnt - d0); end
    endtask

    task automatic test_busy_hold();
        bit ok;
        int d0;
        got.delete();
        d0 = done_cnt;
        viol_cnt = 0;
        force_busy = 1'b1;
        request(4'h2, 16'hA55A);
        repeat (20) @(negedge clk);
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL hold_no_wvld got=%0d want=0", got.size()); end
        force_busy = 1'b0;
        wait_done(d0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL hold_timeout got=no frame_done want=frame_done"); end
        n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL hold_len got=%0d want=4", got.size()); end
        else begin
            n_cmp++; if ({got[0], got[1], got[2], got[3]} !== 32'hADA55A52)
                begin n_bad++; $display("FAIL hold_bytes got=%h%h%h%h want=ADA55A52", got[0], got[1], got[2], got[3]); end
        end
        n_cmp++; if (viol_cnt != 0) begin n_bad++; $display("FAIL hold_handshake got=%0d want=0", viol_cnt); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit ok;
        int d0;
        got.delete();
        d0 = done_cnt;
        request(4'h2, 16'h1234);
        wait_bytes(2, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_two_bytes got=%0d want=2", got.size()); end
        @(negedge clk);
        sys_locked = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++; if (got.size() != 2) begin n_bad++; $display("FAIL abort_no_more got=%0d want=2", got.size()); end
        n_cmp++; if (send_ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready_low got=%b want=0", send_ready); end
        n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL abort_no_done got=%0d want=0", done_cnt - d0); end
        sys_locked = 1'b1;
        @(negedge clk);
        n_cmp++; if (send_ready !== 1'b1) begin n_bad++; $display("FAIL relock_ready got=%b want=1", send_ready); end
        sys_locked = 1'b0; send_req = 1'b1; cmd_in = 4'h2; send_data = 16'h1234;
        @(negedge clk);
        send_req = 1'b0; sys_locked = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (got.size() != 2) begin n_bad++; $display("FAIL lockdrop_req got=%0d want=2", got.size()); end
        n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL lockdrop_done got=%0d want=0", done_cnt - d0); end
        test_frame("relock", 4'h1, 16'h00FF, 4, 32'hCB00FF34);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        got.delete();
        request(4'h2, 16'h1234);
        wait_bytes(1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_mid_start got=%0d want=1", got.size()); end
        @(negedge clk);
        nrst = 1'b0;
        #1;
        n_cmp++; if (uart_wdata !== 8'h00) begin n_bad++; $display("FAIL rst_mid_wdata got=%h want=00", uart_wdata); end
        n_cmp++; if (uart_wvld !== 1'b0) begin n_bad++; $display("FAIL rst_mid_wvld got=%b want=0", uart_wvld); end
        n_cmp++; if (send_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready got=%b want=0", send_ready); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done got=%b want=0", frame_done); end
        repeat (15) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        n_cmp++; if (send_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready_rise got=%b want=1", send_ready); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d0;
        got.delete();
        d0 = done_cnt;
        request(4'h2, 16'h1234);
        wait_bytes(1, ok);
        @(negedge clk);
        send_req = 1'b1; cmd_in = 4'h1; send_data = 16'hFFFF;
        @(negedge clk);
        send_req = 1'b0;
        wait_done(d0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout got=no frame_done want=frame_done"); end
        repeat (40) @(negedge clk);
        n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL b2b_len got=%0d want=4", got.size()); end
        else begin
            n_cmp++; if ({got[0], got[1], got[2], got[3]} !== 32'hAD12348B)
                begin n_bad++; $display("FAIL b2b_bytes got=%h%h%h%h want=AD12348B", got[0], got[1], got[2], got[3]); end
        end
        n_cmp++; if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL b2b_done got=%0d want=1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_frame("ad", 4'h2, 16'h1234, 4, 32'hAD12348B);
        test_frame("cb", 4'h1, 16'h00FF, 4, 32'hCB00FF34);
        test_frame("err", 4'h5, 16'hBEEF, 2, 32'hEEEE0000);
        test_cmd_zero();
        test_busy_hold();
        test_abort();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
